ccss_control_fsm: RTL and testbench

- Parametrised multi-cycle control unit for the CCSS processor.
- Sequences fetch, decode and a variable-length execute phase per instruction.
- Adds three things the first-generation control unit lacks:
  - a memory-ready wait state;
  - a zero-flag reduction across a configurable number of active cores;
  - a start/done handshake.
- Sits between instruction memory/IR and the multi-core datapath. It drives a flat control word (ctrlsig) consumed by the datapath.

---
 rtl/ccss_control_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_ccss_control_fsm.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccss_control_fsm.sv
// ccss_control_fsm: multi-cycle control unit for the CCSS processor.
// Sequences fetch (with a memory-ready wait), decode and a variable-length
// execute phase. It reduces per-core zero flags over the active cores to
// resolve conditional jumps, and provides a start/done handshake.
//
// Ports:
//   clk                 - clock, rising edge
//   rst                 - asynchronous active-low reset
//   start               - begin execution (sampled in IDLE and DONE only)
//   instruction_opcode  - opcode from instruction memory, captured in FETCH2
//   mem_ready           - instruction memory read data valid
//   z                   - per-core zero flags
//   NoC                 - number of active cores
//   ctrlsig             - registered control word for the datapath
//   state               - current state code
//   busy                - high in FETCH1..EXEC
//   end_process         - high in DONE
module ccss_control_fsm #(
  parameter int unsigned OPC_W     = 6,
  parameter int unsigned CTRL_W    = 25,
  parameter int unsigned NOC_W     = 16,
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned MAX_STEPS = 4,
  parameter int unsigned END_OP    = 25,
  parameter int unsigned JMPZ_OP   = 12,
  parameter int unsigned JMPNZ_OP  = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OPC_W-1:0]     instruction_opcode,
  input  logic                 mem_ready,
  input  logic [NUM_CORES-1:0] z,
  input  logic [NOC_W-1:0]     NoC,
  output logic [CTRL_W-1:0]    ctrlsig,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 end_process
);

  // Execute length is clamped to the 4-bit one-hot step field.
  localparam int unsigned MaxSteps = (MAX_STEPS < 1) ? 1 : ((MAX_STEPS > 4) ? 4 : MAX_STEPS);

  localparam logic [OPC_W-1:0] EndOp   = OPC_W'(END_OP);
  localparam logic [OPC_W-1:0] JmpzOp  = OPC_W'(JMPZ_OP);
  localparam logic [OPC_W-1:0] JmpnzOp = OPC_W'(JMPNZ_OP);
  localparam logic [NOC_W-1:0] NumCrs  = NOC_W'(NUM_CORES);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch1 = 3'd1,
    StFetch2 = 3'd2,
    StDecode = 3'd3,
    StExec   = 3'd4,
    StDone   = 3'd5
  } state_e;

  state_e             r_state;
  logic [OPC_W-1:0]   r_opcode;
  logic [1:0]         r_step;
  logic [1:0]         r_last;
  logic               r_jump;
  logic [CTRL_W-1:0]  r_ctrl;
  logic               r_busy;
  logic               r_end;

  state_e             w_state_nxt;
  logic [OPC_W-1:0]   w_opcode_nxt;
  logic [1:0]         w_step_nxt;
  logic [1:0]         w_last_nxt;
  logic               w_jump_nxt;
  logic [CTRL_W-1:0]  w_ctrl_nxt;
  logic               w_busy_nxt;
  logic               w_end_nxt;

  logic [NOC_W-1:0]     w_active;
  logic [NUM_CORES-1:0] w_mask;
  logic                 w_zall;
  logic                 w_jump_flag;
  logic [2:0]           w_steps;
  logic [1:0]           w_last_calc;

  // Active-core mask: NoC clamped to [1, NUM_CORES].
  always_comb begin
    w_active = NoC;
    if (NoC == '0) begin
      w_active = NOC_W'(1);
    end else if (NoC > NumCrs) begin
      w_active = NumCrs;
    end
    w_mask = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      w_mask[i] = (NOC_W'(i) < w_active);
    end
    // Inactive cores are forced to 1 so they do not affect the AND.
    w_zall = &(z | ~w_mask);
  end

  always_comb begin
    w_jump_flag = 1'b0;
    if (r_opcode == JmpzOp) begin
      w_jump_flag = w_zall;
    end else if (r_opcode == JmpnzOp) begin
      w_jump_flag = ~w_zall;
    end
  end

  // Last step index for the opcode held in the opcode register.
  always_comb begin
    w_steps = 3'(r_opcode[1:0]) + 3'd1;
    if (w_steps > 3'(MaxSteps)) begin
      w_steps = 3'(MaxSteps);
    end
    if ((r_opcode == JmpzOp) || (r_opcode == JmpnzOp)) begin
      w_steps = 3'd1;
    end
    w_last_calc = 2'(w_steps - 3'd1);
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_opcode_nxt = r_opcode;
    w_step_nxt   = r_step;
    w_last_nxt   = r_last;
    w_jump_nxt   = r_jump;
    case (r_state)
      StIdle: begin
        if (start) w_state_nxt = StFetch1;
      end
      StFetch1: begin
        if (mem_ready) w_state_nxt = StFetch2;
      end
      StFetch2: begin
        w_opcode_nxt = instruction_opcode;
        w_state_nxt  = StDecode;
      end
      StDecode: begin
        w_jump_nxt = w_jump_flag;
        w_step_nxt = 2'd0;
        w_last_nxt = w_last_calc;
        if (r_opcode == EndOp) begin
          w_state_nxt = StDone;
        end else if (r_opcode == '0) begin
          w_state_nxt = StFetch1;
        end else begin
          w_state_nxt = StExec;
        end
      end
      StExec: begin
        if (r_step == r_last) begin
          w_state_nxt = StFetch1;
        end else begin
          w_step_nxt = r_step + 2'd1;
        end
      end
      StDone: begin
        if (start) w_state_nxt = StFetch1;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs decoded from the next state and registered alongside it, so the
  // visible outputs are a pure function of the current registered state.
  always_comb begin
    w_ctrl_nxt = '0;
    w_busy_nxt = 1'b0;
    w_end_nxt  = 1'b0;
    case (w_state_nxt)
      StFetch1: begin
        w_ctrl_nxt[1] = 1'b1;
        w_busy_nxt    = 1'b1;
      end
      StFetch2: begin
        w_ctrl_nxt[0]  = 1'b1;
        w_ctrl_nxt[19] = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      StDecode: begin
        w_ctrl_nxt[3] = 1'b1;
        w_busy_nxt    = 1'b1;
      end
      StExec: begin
        w_ctrl_nxt[2]    = w_jump_nxt && (w_step_nxt == 2'd0);
        w_ctrl_nxt[7:4]  = 4'b0001 << w_step_nxt;
        w_ctrl_nxt[13:8] = 6'(w_opcode_nxt);
        w_busy_nxt       = 1'b1;
      end
      StDone: begin
        w_end_nxt = 1'b1;
      end
      default: begin
        w_ctrl_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_opcode <= '0;
      r_step   <= 2'd0;
      r_last   <= 2'd0;
      r_jump   <= 1'b0;
      r_ctrl   <= '0;
      r_busy   <= 1'b0;
      r_end    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_opcode <= w_opcode_nxt;
      r_step   <= w_step_nxt;
      r_last   <= w_last_nxt;
      r_jump   <= w_jump_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_busy   <= w_busy_nxt;
      r_end    <= w_end_nxt;
    end
  end

  assign ctrlsig     = r_ctrl;
  assign state       = r_state;
  assign busy        = r_busy;
  assign end_process = r_end;

endmodule

// File: tb/tb_ccss_control_fsm.sv
// Self-checking bench for ccss_control_fsm: a table of directed vectors for
// whole instruction sequences, plus hand-written sequences for reset, memory
// wait, DONE hold/restart and a MAX_STEPS=2 instance.
module tb_ccss_control_fsm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  instruction_opcode;
  logic        mem_ready;
  logic [3:0]  z;
  logic [15:0] noc;

  logic [24:0] ctrlsig;
  logic [2:0]  state;
  logic        busy;
  logic        end_process;

  logic [24:0] ctrlsig2;
  logic [2:0]  state2;
  logic        busy2;
  logic        end_process2;

  int unsigned n_pass;
  int unsigned n_total;

  ccss_control_fsm u_dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .instruction_opcode (instruction_opcode),
    .mem_ready          (mem_ready),
    .z                  (z),
    .NoC                (noc),
    .ctrlsig            (ctrlsig),
    .state              (state),
    .busy               (busy),
    .end_process        (end_process)
  );

  ccss_control_fsm #(
    .MAX_STEPS (2)
  ) u_dut2 (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .instruction_opcode (instruction_opcode),
    .mem_ready          (mem_ready),
    .z                  (z),
    .NoC                (noc),
    .ctrlsig            (ctrlsig2),
    .state              (state2),
    .busy               (busy2),
    .end_process        (end_process2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        mr;
    logic [5:0]  op;
    logic [15:0] nc;
    logic [3:0]  zz;
    logic [2:0]  es;
    logic [31:0] ec;
    logic        eb;
    logic        ee;
  } vec_t;

  vec_t vt [64];
  int   n_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic mr, input logic [5:0] op, input logic [15:0] nc,
                     input logic [3:0] zz, input logic [2:0] es, input logic [31:0] ec);
    vt[n_vec].st = st;
    vt[n_vec].mr = mr;
    vt[n_vec].op = op;
    vt[n_vec].nc = nc;
    vt[n_vec].zz = zz;
    vt[n_vec].es = es;
    vt[n_vec].ec = ec;
    vt[n_vec].eb = (es >= 3'd1) && (es <= 3'd4);
    vt[n_vec].ee = (es == 3'd5);
    n_vec++;
  endtask

  // One instruction fetched from FETCH1: FETCH2, DECODE, then given EXEC words.
  task automatic add_instr(input logic [5:0] op, input logic [15:0] nc, input logic [3:0] zz,
                           input int n_exec, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ew [4];
    ew[0] = e0; ew[1] = e1; ew[2] = e2; ew[3] = e3;
    add(1'b0, 1'b1, op, nc, zz, 3'd2, 32'h80001);
    add(1'b0, 1'b1, op, nc, zz, 3'd3, 32'h8);
    for (int i = 0; i < n_exec; i++) begin
      add(1'b0, 1'b1, op, nc, zz, 3'd4, ew[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [2:0] es, input logic [31:0] ec,
                            input logic eb, input logic ee);
    check({name, ".state"}, 32'(state), 32'(es));
    check({name, ".ctrl"}, 32'(ctrlsig), ec);
    check({name, ".busy"}, 32'(busy), 32'(eb));
    check({name, ".end"}, 32'(end_process), 32'(ee));
  endtask

  initial begin
    int cnt1;
    int cnt2;
    int hi2;

    n_pass = 0;
    n_total = 0;
    n_vec = 0;
    rst = 1'b0;
    start = 1'b0;
    mem_ready = 1'b0;
    instruction_opcode = '0;
    z = '0;
    noc = 16'd4;

    // Opcode 3: four execute steps.
    add(1'b1, 1'b1, 6'd3, 16'd4, 4'h0, 3'd1, 32'h2);
    add_instr(6'd3, 16'd4, 4'h0, 4, 32'h310, 32'h320, 32'h340, 32'h380);
    add(1'b0, 1'b1, 6'd3, 16'd4, 4'h0, 3'd1, 32'h2);
    // NOP goes straight back to FETCH1.
    add_instr(6'd0, 16'd4, 4'h0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b1, 6'd0, 16'd4, 4'h0, 3'd1, 32'h2);
    // JMPZ, two active cores, all zero: taken.
    add_instr(6'd12, 16'd2, 4'hF, 1, 32'hC14, 0, 0, 0);
    add(1'b0, 1'b1, 6'd12, 16'd2, 4'hF, 3'd1, 32'h2);
    // JMPZ, core 1 non-zero: not taken.
    add_instr(6'd12, 16'd2, 4'hD, 1, 32'hC10, 0, 0, 0);
    add(1'b0, 1'b1, 6'd12, 16'd2, 4'hD, 3'd1, 32'h2);
    // JMPZ, NoC=0 counts as one core: taken.
    add_instr(6'd12, 16'd0, 4'h1, 1, 32'hC14, 0, 0, 0);
    add(1'b0, 1'b1, 6'd12, 16'd0, 4'h1, 3'd1, 32'h2);
    // JMPNZ, core 3 non-zero: taken, still one step.
    add_instr(6'd13, 16'd4, 4'h7, 1, 32'hD14, 0, 0, 0);
    add(1'b0, 1'b1, 6'd13, 16'd4, 4'h7, 3'd1, 32'h2);
    // JMPNZ, all zero: not taken.
    add_instr(6'd13, 16'd4, 4'hF, 1, 32'hD10, 0, 0, 0);
    add(1'b0, 1'b1, 6'd13, 16'd4, 4'hF, 3'd1, 32'h2);
    // Opcode 5: two steps, never a jump.
    add_instr(6'd5, 16'd4, 4'hF, 2, 32'h510, 32'h520, 0, 0);
    add(1'b0, 1'b1, 6'd5, 16'd4, 4'hF, 3'd1, 32'h2);
    // END: DONE.
    add_instr(6'd25, 16'd4, 4'h0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b1, 6'd25, 16'd4, 4'h0, 3'd5, 32'h0);

    // Reset state.
    tick();
    tick();
    check_outs("reset", 3'd0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      start = vt[i].st;
      mem_ready = vt[i].mr;
      instruction_opcode = vt[i].op;
      noc = vt[i].nc;
      z = vt[i].zz;
      tick();
      check_outs($sformatf("vec%0d", i), vt[i].es, vt[i].ec, vt[i].eb, vt[i].ee);
    end

    // DONE holds without start.
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs($sformatf("done_hold%0d", i), 3'd5, 32'h0, 1'b0, 1'b0 | 1'b1);
    end
    // Restart straight from DONE.
    start = 1'b1;
    instruction_opcode = 6'd3;
    mem_ready = 1'b1;
    tick();
    check_outs("restart", 3'd1, 32'h2, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst.state", 32'(state), 32'd4);
    // Asynchronous reset mid-EXEC, observed before the next edge.
    #2;
    rst = 1'b0;
    #1;
    check_outs("async_rst", 3'd0, 32'h0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("idle%0d", i), 3'd0, 32'h0, 1'b0, 1'b0);
    end

    // Memory wait in FETCH1.
    start = 1'b1;
    mem_ready = 1'b0;
    tick();
    start = 1'b0;
    check_outs("wait0", 3'd1, 32'h2, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_outs($sformatf("wait%0d", i), 3'd1, 32'h2, 1'b1, 1'b0);
    end
    mem_ready = 1'b1;
    tick();
    check_outs("wait_done", 3'd2, 32'h80001, 1'b1, 1'b0);

    // MAX_STEPS=2 instance against the default one on opcode 3.
    rst = 1'b0;
    #2;
    rst = 1'b1;
    start = 1'b1;
    instruction_opcode = 6'd3;
    mem_ready = 1'b1;
    cnt1 = 0;
    cnt2 = 0;
    hi2 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
      if (state == 3'd4) cnt1++;
      if (state2 == 3'd4) cnt2++;
      if (ctrlsig2[7:6] != 2'b00) hi2++;
    end
    check("max4.exec_cycles", 32'(cnt1), 32'd4);
    check("max2.exec_cycles", 32'(cnt2), 32'd2);
    check("max2.high_step_bits", 32'(hi2), 32'd0);
    check("max2.state_end", 32'(state2), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
